// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
package ps2_host_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQUEST = 3'd2,
    ST_SEND    = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } tx_state_e;

  // 8 data + parity + stop are driven by the host; the 11th edge carries the device ack.
  localparam int HOST_BITS   = 10;
  localparam int FRAME_EDGES = 11;

  // Frame as shifted out LSB first: {stop, odd parity, data}.
  function automatic logic [HOST_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchroniser chain and the one-cycle history flop.
  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte, check ack.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int INHIBIT_CLKS = 1000,
  parameter int TIMEOUT_CLKS = 20000,
  parameter int CNT_BITS     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rxInhibit,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe
);

  localparam logic [CNT_BITS-1:0] INH_LAST = CNT_BITS'(INHIBIT_CLKS - 1);
  localparam logic [CNT_BITS-1:0] TO_LAST  = CNT_BITS'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [3:0]          LAST_BIT = 4'(HOST_BITS - 1);

  tx_state_e               state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [HOST_BITS-1:0]    shift_q, shift_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    clk_oe_q, clk_oe_d;
  logic                    data_oe_q, data_oe_d;

  logic                    clk_sync, clk_fall;
  logic                    data_sync, data_fall_unused;
  logic [CNT_BITS-1:0]     cnt_inc;
  logic                    abort;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .rst_n     (reset),
    .line_in   (ps2ClkIn),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .rst_n     (reset),
    .line_in   (ps2DataIn),
    .line_sync (data_sync),
    .line_fall (data_fall_unused)
  );

  // Saturating increment so a stalled bus can never wrap the counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next-state and output logic; abort collapses every timeout/nack path to one release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (txStart && !busy_q) begin
          shift_d  = build_frame(txData);
          cnt_d    = '0;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        clk_oe_d  = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[HOST_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = '0;
          if (bit_cnt_q == LAST_BIT) state_d = ST_ACK;
        end else if (cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_sync) state_d = ST_RELEASE;
          else            abort   = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    if (abort) begin
      error_d   = 1'b1;
      busy_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign busy      = busy_q;
  assign rxInhibit = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign ps2ClkOe  = clk_oe_q;
  assign ps2DataOe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter with an open-drain bus and a behavioural PS/2 device.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

  localparam int INH  = 100;
  localparam int TO   = 300;
  localparam int CB   = 9;
  localparam int HALF = 20;   // device half period in clk cycles (1 us clk -> 40 us period)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txStart = 1'b0;
  logic       busy, done, error, rxInhibit, ps2ClkOe, ps2DataOe;
  logic       ps2ClkIn, ps2DataIn;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Wired-AND bus: host pulls low through its enables, device through its own drivers.
  assign ps2ClkIn  = ~ps2ClkOe & dev_clk;
  assign ps2DataIn = ~ps2DataOe & dev_data;

  ps2_host_transmitter #(
    .INHIBIT_CLKS (INH),
    .TIMEOUT_CLKS (TO),
    .CNT_BITS     (CB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .txData    (txData),
    .txStart   (txStart),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rxInhibit (rxInhibit),
    .ps2ClkIn  (ps2ClkIn),
    .ps2DataIn (ps2DataIn),
    .ps2ClkOe  (ps2ClkOe),
    .ps2DataOe (ps2DataOe)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] dev_bits;
  int         last_fall_cyc;
  bit         req_seen;
  int         m_done, m_err, m_inh, m_clkoe, m_err_cyc, m_inhib_bad;
  bit         m_timeout;

  // Expected line sequence: data LSB first, then a parity bit making the ones count odd, then stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d};
  endfunction

  task automatic issue(input logic [7:0] d, input bit extra);
    @(negedge clk);
    txData  = d;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    if (extra) begin
      repeat (30) @(negedge clk);
      txData  = 8'hAA;
      txStart = 1'b1;
      @(negedge clk);
      txStart = 1'b0;
      txData  = 8'h00;
    end
  endtask

  // Device: waits for request-to-send, clocks n_fall edges, samples host data on rising edges.
  task automatic device(input int n_fall, input bit ack);
    int w;
    w = 0;
    dev_bits = 'x;
    req_seen = 1'b0;
    while (!(ps2ClkIn === 1'b1 && ps2DataIn === 1'b0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) return;
    req_seen = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= n_fall; e++) begin
      if (e == 11 && ack) dev_data = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      if (e == n_fall && n_fall < 11) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (e <= 10) dev_bits[e-1] = ps2DataIn;
      if (e == 11) dev_data = 1'b1;
      repeat (HALF - 5) @(negedge clk);
    end
  endtask

  task automatic monitor();
    int w;
    bit seen;
    w = 0; seen = 0;
    m_done = 0; m_err = 0; m_inh = 0; m_clkoe = 0; m_err_cyc = -1; m_inhib_bad = 0; m_timeout = 0;
    while (w < 5000) begin
      @(posedge clk); #1;
      w++;
      if (ps2ClkOe) m_clkoe++;
      if (ps2ClkOe && !ps2DataOe) m_inh++;
      if (done) m_done++;
      if (error) begin
        m_err++;
        if (m_err_cyc < 0) m_err_cyc = cyc;
      end
      if (rxInhibit !== busy) m_inhib_bad++;
      if (busy) seen = 1;
      else if (seen) break;
    end
    if (w >= 5000) m_timeout = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) m_done++;
      if (error) m_err++;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int n_fall, input bit ack, input bit extra);
    fork
      issue(d, extra);
      monitor();
      device(n_fall, ack);
    join
  endtask

  task automatic test_reset();
    #10;
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0)     begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (rxInhibit !== 1'b0) begin n_bad++; $display("FAIL reset_rxinhibit: got %b want 0", rxInhibit); end
    n_cmp++; if (ps2ClkOe !== 1'b0)  begin n_bad++; $display("FAIL reset_clkoe: got %b want 0", ps2ClkOe); end
    n_cmp++; if (ps2DataOe !== 1'b0) begin n_bad++; $display("FAIL reset_dataoe: got %b want 0", ps2DataOe); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(8'hED, 11, 1'b1, 1'b0);
    n_cmp++; if (m_timeout !== 1'b0) begin n_bad++; $display("FAIL basic_finish: busy never cleared"); end
    n_cmp++; if (dev_bits !== ref_frame(8'hED)) begin n_bad++; $display("FAIL basic_bits: got %b want %b", dev_bits, ref_frame(8'hED)); end
    n_cmp++; if (m_inh != INH) begin n_bad++; $display("FAIL basic_inhibit_len: got %0d want %0d", m_inh, INH); end
    n_cmp++; if (m_clkoe != INH + 1) begin n_bad++; $display("FAIL basic_clkoe_len: got %0d want %0d", m_clkoe, INH + 1); end
    n_cmp++; if (m_done != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", m_done); end
    n_cmp++; if (m_err != 0) begin n_bad++; $display("FAIL basic_error_count: got %0d want 0", m_err); end
    n_cmp++; if (m_inhib_bad != 0) begin n_bad++; $display("FAIL basic_rxinhibit: %0d cycles differ from busy", m_inhib_bad); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_parity();
    logic [7:0] pats [3];
    pats[0] = 8'hFF; pats[1] = 8'h00; pats[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      run_frame(pats[i], 11, 1'b1, 1'b0);
      n_cmp++; if (dev_bits !== ref_frame(pats[i])) begin n_bad++; $display("FAIL parity_bits_%02h: got %b want %b", pats[i], dev_bits, ref_frame(pats[i])); end
      n_cmp++; if (m_done != 1) begin n_bad++; $display("FAIL parity_done_%02h: got %0d want 1", pats[i], m_done); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      run_frame(d, 11, 1'b1, 1'b0);
      n_cmp++; if (dev_bits !== ref_frame(d)) begin n_bad++; $display("FAIL random_bits_%02h: got %b want %b", d, dev_bits, ref_frame(d)); end
      n_cmp++; if (m_done != 1 || m_err != 0) begin n_bad++; $display("FAIL random_result_%02h: done %0d error %0d want 1/0", d, m_done, m_err); end
    end
  endtask

  task automatic test_no_ack();
    run_frame(8'hF3, 11, 1'b0, 1'b0);
    n_cmp++; if (m_err != 1) begin n_bad++; $display("FAIL noack_error_count: got %0d want 1", m_err); end
    n_cmp++; if (m_done != 0) begin n_bad++; $display("FAIL noack_done_count: got %0d want 0", m_done); end
    n_cmp++; if (ps2ClkOe !== 1'b0 || ps2DataOe !== 1'b0) begin n_bad++; $display("FAIL noack_release: clkoe %b dataoe %b want 0/0", ps2ClkOe, ps2DataOe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noack_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    run_frame(8'h5C, 5, 1'b1, 1'b0);
    n_cmp++; if (m_err != 1 || m_done != 0) begin n_bad++; $display("FAIL timeout_result: error %0d done %0d want 1/0", m_err, m_done); end
    n_cmp++; if (m_err_cyc - last_fall_cyc != TO + 3) begin n_bad++; $display("FAIL timeout_latency: got %0d want %0d", m_err_cyc - last_fall_cyc, TO + 3); end
    n_cmp++; if (ps2ClkOe !== 1'b0 || ps2DataOe !== 1'b0) begin n_bad++; $display("FAIL timeout_release: clkoe %b dataoe %b want 0/0", ps2ClkOe, ps2DataOe); end
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    fork
      issue(8'hED, 1'b0);
      device(4, 1'b1);
    join
    repeat (6) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    #100;
    reset = 1'b0;
    #10;
    n_cmp++; if (ps2ClkOe !== 1'b0)  begin n_bad++; $display("FAIL midreset_clkoe: got %b want 0", ps2ClkOe); end
    n_cmp++; if (ps2DataOe !== 1'b0) begin n_bad++; $display("FAIL midreset_dataoe: got %b want 0", ps2DataOe); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'hF4, 11, 1'b1, 1'b0);
    n_cmp++; if (dev_bits !== ref_frame(8'hF4)) begin n_bad++; $display("FAIL midreset_next_bits: got %b want %b", dev_bits, ref_frame(8'hF4)); end
    n_cmp++; if (m_done != 1 || m_err != 0) begin n_bad++; $display("FAIL midreset_next_result: done %0d error %0d want 1/0", m_done, m_err); end
  endtask

  task automatic test_busy_ignore();
    run_frame(8'hED, 11, 1'b1, 1'b1);
    n_cmp++; if (dev_bits !== ref_frame(8'hED)) begin n_bad++; $display("FAIL ignore_bits: got %b want %b", dev_bits, ref_frame(8'hED)); end
    n_cmp++; if (m_done != 1 || m_err != 0) begin n_bad++; $display("FAIL ignore_result: done %0d error %0d want 1/0", m_done, m_err); end
    repeat (150) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ps2ClkOe !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: busy %b clkoe %b want 0/0", busy, ps2ClkOe); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_random();
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
